// File: rtl/cmd_fanout.sv
// cmd_fanout: routes one command stream to NCHAN element channels by address.
// Each channel owns a DEPTH-entry first-word-fall-through FIFO that drains
// under el_ready, followed by a stage-0 register and PIPE extra stages.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   cmd_in/cmda_in      - command word and address, valid with cstrobe_in
//   cstrobe_in          - one command per high cycle
//   el_ready[NCHAN]     - per-channel element ready (pop enable)
//   cmd_out             - per-channel command, channel c at [c*CMD_W +: CMD_W]
//   cstrobe_out[NCHAN]  - per-channel one-cycle delivery strobe
//   fill                - per-channel FIFO occupancy, FW bits each
//   overflow[NCHAN]     - sticky full-drop flags, cleared by overflow_clr
//   invalid_cnt         - saturating count of invalid-address drops
module cmd_fanout #(
  parameter int unsigned NCHAN  = 8,
  parameter int unsigned CMD_W  = 64,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PIPE   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CMD_W-1:0]              cmd_in,
  input  logic [ADDR_W-1:0]             cmda_in,
  input  logic                          cstrobe_in,
  input  logic [NCHAN-1:0]              el_ready,
  output logic [NCHAN*CMD_W-1:0]        cmd_out,
  output logic [NCHAN-1:0]              cstrobe_out,
  output logic [NCHAN*($clog2(DEPTH)+1)-1:0] fill,
  output logic [NCHAN-1:0]              overflow,
  input  logic                          overflow_clr,
  output logic [7:0]                    invalid_cnt
);

  localparam int unsigned CHAN_AW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned FW      = PW + 1;

  logic                 bcast;
  logic [CHAN_AW-1:0]   sel;
  logic                 sel_ok;
  logic                 invalid_drop;
  logic [NCHAN-1:0]     push_req;
  logic                 unused_addr;

  // Only the channel field and the broadcast bit are decoded.
  assign unused_addr = ^cmda_in;

  // Address decode into per-channel push requests.
  always_comb begin
    bcast        = cmda_in[CHAN_AW];
    sel          = cmda_in[CHAN_AW-1:0];
    sel_ok       = {1'b0, sel} < (CHAN_AW+1)'(NCHAN);
    invalid_drop = cstrobe_in && !bcast && !sel_ok;
    push_req     = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      push_req[c] = cstrobe_in && (bcast || (sel_ok && (sel == CHAN_AW'(c))));
    end
  end

  // Saturating invalid-address drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invalid_cnt <= 8'd0;
    end else if (invalid_drop && (invalid_cnt != 8'hFF)) begin
      invalid_cnt <= invalid_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [FW-1:0]    count;
    logic [CMD_W-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             bypass;
    logic             pop;
    logic             wr;
    logic             deliver;
    logic             ovf_set;
    logic [CMD_W-1:0] head;
    logic [PIPE:0]    sv;
    logic [CMD_W-1:0] sd [PIPE+1];

    // An empty FIFO with a ready element forwards the incoming word straight
    // to stage 0, giving the 1+PIPE cycle latency; the FIFO is bypassed.
    always_comb begin
      empty   = (count == '0);
      full    = (count == FW'(DEPTH));
      bypass  = push_req[g] && empty && el_ready[g];
      pop     = !empty && el_ready[g];
      wr      = push_req[g] && !bypass && (!full || pop);
      ovf_set = push_req[g] && full && !pop;
      deliver = bypass || pop;
      head    = bypass ? cmd_in : mem[rd_ptr];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr)  wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + FW'(wr) - FW'(pop);
      end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= cmd_in;
    end

    // Output pipeline; data only advances with its valid so cmd_out holds.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sv <= '0;
        for (int unsigned k = 0; k <= PIPE; k++) sd[k] <= '0;
      end else begin
        sv[0] <= deliver;
        if (deliver) sd[0] <= head;
        for (int unsigned k = 1; k <= PIPE; k++) begin
          sv[k] <= sv[k-1];
          if (sv[k-1]) sd[k] <= sd[k-1];
        end
      end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        overflow[g] <= 1'b0;
      end else if (ovf_set) begin
        overflow[g] <= 1'b1;
      end else if (overflow_clr) begin
        overflow[g] <= 1'b0;
      end
    end

    assign cstrobe_out[g]              = sv[PIPE];
    assign cmd_out[g*CMD_W +: CMD_W]   = sd[PIPE];
    assign fill[g*FW +: FW]            = count;
  end

endmodule
